// File: rtl/cache_fill_ctrl.sv
// Block-fill controller: arbitrates cache miss sources and issues one word read per cycle.
// It steers the returning words into the granted cache, then writes that cache's tag/valid once.
module cache_fill_ctrl #(
    parameter int ADDR_W          = 16,
    parameter int WORD_BYTES      = 2,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int NUM_REQ         = 2,
    parameter int CWF             = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 miss_req,
    input  logic [NUM_REQ*ADDR_W-1:0]          miss_addr,
    output logic                               mem_rd_en,
    output logic [ADDR_W-1:0]                  mem_addr,
    input  logic                               mem_data_valid,
    output logic [NUM_REQ-1:0]                 fill_data_wen,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic [NUM_REQ-1:0]                 fill_tag_wen,
    output logic [NUM_REQ-1:0]                 grant,
    output logic                               busy
);

    localparam int IDX_W   = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W   = IDX_W + 1;
    localparam int BYTE_SH = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0]  FULL     = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(WORDS_PER_BLOCK * WORD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, TAG} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [IDX_W-1:0]    start_q, start_d;
    logic [CNT_W-1:0]    iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]    ret_cnt_q, ret_cnt_d;

    logic [NUM_REQ-1:0]  win_oh;
    logic [ADDR_W-1:0]   win_addr;
    logic [IDX_W-1:0]    iss_word;
    logic [IDX_W-1:0]    ret_word;

    // Fixed priority: the highest-indexed requester seen last in the scan wins.
    always_comb begin
        win_oh   = '0;
        win_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (miss_req[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_addr  = miss_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // IDX_W-bit sums wrap inside the block, so the tag bits of base_q are never disturbed.
    assign iss_word = start_q + iss_cnt_q[IDX_W-1:0];
    assign ret_word = start_q + ret_cnt_q[IDX_W-1:0];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        base_d        = base_q;
        start_d       = start_q;
        iss_cnt_d     = iss_cnt_q;
        ret_cnt_d     = ret_cnt_q;
        mem_rd_en     = 1'b0;
        mem_addr      = '0;
        fill_data_wen = '0;
        fill_word_idx = '0;
        fill_tag_wen  = '0;

        case (state_q)
            IDLE: begin
                if (|miss_req) begin
                    grant_d   = win_oh;
                    base_d    = win_addr & ~BLK_MASK;
                    start_d   = (CWF != 0) ? IDX_W'(win_addr >> BYTE_SH) : '0;
                    iss_cnt_d = '0;
                    ret_cnt_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE, DRAIN: begin
                // Returns can overlap issue, so they are counted in both states.
                if (mem_data_valid && (ret_cnt_q != FULL)) begin
                    fill_data_wen = grant_q;
                    fill_word_idx = ret_word;
                    ret_cnt_d     = ret_cnt_q + 1'b1;
                end
                if (state_q == ISSUE) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = base_q | (ADDR_W'(iss_word) << BYTE_SH);
                    iss_cnt_d = iss_cnt_q + 1'b1;
                    if (iss_cnt_q == LAST)
                        state_d = (ret_cnt_d == FULL) ? TAG : DRAIN;
                end else if (ret_cnt_d == FULL) begin
                    state_d = TAG;
                end
            end
            TAG: begin
                fill_tag_wen = grant_q;
                grant_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            base_q    <= '0;
            start_q   <= '0;
            iss_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            base_q    <= base_d;
            start_q   <= start_d;
            iss_cnt_q <= iss_cnt_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: two instances (CWF=0 and CWF=1) share stimulus.
// Each instance is compared every cycle against a transaction-level model; directed literals pin the model.
module tb_cache_fill_ctrl;
    localparam int WPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  miss_req = 2'b00;
    logic [31:0] miss_addr = 32'h0;
    logic        stray = 1'b0;
    logic        slow = 1'b0;
    logic [2:0]  pipe;
    logic        mem_data_valid;

    logic        rd_w   [2];
    logic [15:0] addr_w [2];
    logic [1:0]  wen_w  [2];
    logic [2:0]  idx_w  [2];
    logic [1:0]  tag_w  [2];
    logic [1:0]  gnt_w  [2];
    logic        busy_w [2];

    always #5 clk = ~clk;

    cache_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .WORDS_PER_BLOCK(8), .NUM_REQ(2), .CWF(0)) u_dut0 (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .mem_rd_en(rd_w[0]), .mem_addr(addr_w[0]), .mem_data_valid(mem_data_valid),
        .fill_data_wen(wen_w[0]), .fill_word_idx(idx_w[0]), .fill_tag_wen(tag_w[0]),
        .grant(gnt_w[0]), .busy(busy_w[0]));

    cache_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .WORDS_PER_BLOCK(8), .NUM_REQ(2), .CWF(1)) u_dut1 (
        .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
        .mem_rd_en(rd_w[1]), .mem_addr(addr_w[1]), .mem_data_valid(mem_data_valid),
        .fill_data_wen(wen_w[1]), .fill_word_idx(idx_w[1]), .fill_tag_wen(tag_w[1]),
        .grant(gnt_w[1]), .busy(busy_w[1]));

    // Memory: returns in issue order, 0 or 3 cycles of latency, plus injectable stray strobes.
    always @(posedge clk or negedge rst) begin
        if (!rst) pipe <= 3'b000;
        else      pipe <= {pipe[1:0], rd_w[0]};
    end
    assign mem_data_valid = stray | (slow ? pipe[2] : rd_w[0]);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state per instance: an in-flight fill as owner/base/start plus issue and return tallies.
    bit m_act [2];
    bit m_tagp[2];
    int m_own [2];
    int m_base[2];
    int m_start[2];
    int m_iss [2];
    int m_ret [2];

    int addr_q0[$], addr_q1[$], idx_q0[$], idx_q1[$], tag_q0[$], tag_q1[$];
    int gnt0_cyc = -1;
    int tag1_cyc = -1;

    task automatic model_step(input int d);
        int e_grant, e_rd, e_addr, e_wb, e_idx, e_tag, a;
        string p;
        p = $sformatf("d%0d ", d);
        if (!rst) begin
            chk({p, "rst busy"},  int'(busy_w[d]), 0);
            chk({p, "rst grant"}, int'(gnt_w[d]), 0);
            chk({p, "rst rd_en"}, int'(rd_w[d]), 0);
            chk({p, "rst wen"},   int'(wen_w[d]), 0);
            chk({p, "rst tag"},   int'(tag_w[d]), 0);
            m_act[d]  = 1'b0;
            m_tagp[d] = 1'b0;
            return;
        end
        e_grant = m_act[d] ? (1 << m_own[d]) : 0;
        e_rd    = (m_act[d] && !m_tagp[d] && m_iss[d] < WPB) ? 1 : 0;
        e_addr  = e_rd ? m_base[d] + ((m_start[d] + m_iss[d]) % WPB) * 2 : 0;
        e_wb    = (m_act[d] && !m_tagp[d] && mem_data_valid && m_ret[d] < WPB) ? 1 : 0;
        e_idx   = e_wb ? (m_start[d] + m_ret[d]) % WPB : 0;
        e_tag   = (m_act[d] && m_tagp[d]) ? (1 << m_own[d]) : 0;

        chk({p, "busy"},     int'(busy_w[d]), int'(m_act[d]));
        chk({p, "grant"},    int'(gnt_w[d]), e_grant);
        chk({p, "rd_en"},    int'(rd_w[d]), e_rd);
        chk({p, "mem_addr"}, int'(addr_w[d]), e_addr);
        chk({p, "data_wen"}, int'(wen_w[d]), e_wb ? e_grant : 0);
        chk({p, "word_idx"}, int'(idx_w[d]), e_idx);
        chk({p, "tag_wen"},  int'(tag_w[d]), e_tag);

        if (d == 0) begin
            if (rd_w[0])       addr_q0.push_back(int'(addr_w[0]));
            if (|wen_w[0])     idx_q0.push_back(int'(idx_w[0]));
            if (|tag_w[0])     tag_q0.push_back(tag_w[0][1] ? 1 : 0);
            if (gnt_w[0] == 2'b01 && gnt0_cyc < 0) gnt0_cyc = cyc;
            if (tag_w[0] == 2'b10) tag1_cyc = cyc;
        end else begin
            if (rd_w[1])       addr_q1.push_back(int'(addr_w[1]));
            if (|wen_w[1])     idx_q1.push_back(int'(idx_w[1]));
            if (|tag_w[1])     tag_q1.push_back(tag_w[1][1] ? 1 : 0);
        end

        if (!m_act[d]) begin
            if (miss_req != 2'b00) begin
                m_own[d]   = miss_req[1] ? 1 : 0;
                a          = int'(miss_addr[m_own[d]*16 +: 16]);
                m_base[d]  = a & 'hFFF0;
                m_start[d] = (d == 1) ? (a / 2) % WPB : 0;
                m_iss[d]   = 0;
                m_ret[d]   = 0;
                m_act[d]   = 1'b1;
                m_tagp[d]  = 1'b0;
            end
        end else if (m_tagp[d]) begin
            m_act[d]  = 1'b0;
            m_tagp[d] = 1'b0;
        end else begin
            if (e_rd != 0) m_iss[d]++;
            if (e_wb != 0) m_ret[d]++;
            if (m_iss[d] == WPB && m_ret[d] == WPB) m_tagp[d] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        addr_q0.delete(); addr_q1.delete();
        idx_q0.delete();  idx_q1.delete();
        tag_q0.delete();  tag_q1.delete();
        gnt0_cyc = -1;
        tag1_cyc = -1;
    endtask

    task automatic chk_q(input string name, input int q[$], input int e[$]);
        chk({name, " count"}, q.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s[%0d]", name, i), (i < q.size()) ? q[i] : -1, e[i]);
    endtask

    // Raise misses and drop each source's request after its tag write, within a cycle budget.
    task automatic fill(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1);
        int n;
        logic [1:0] clr;
        n = 0;
        miss_addr = {a1, a0};
        miss_req  = req;
        while (miss_req != 2'b00 && n < 200) begin
            @(negedge clk);
            clr = tag_w[0];
            @(posedge clk);
            #1;
            miss_req = miss_req & ~clr;
            n++;
        end
        chk("fill completes", int'(miss_req), 0);
        miss_req = 2'b00;
        tick(2);
    endtask

    initial begin
        int e[$];
        tick(3);
        chk("reset busy",  int'(busy_w[0]), 0);
        chk("reset grant", int'(gnt_w[1]), 0);
        chk("reset rd_en", int'(rd_w[0]), 0);
        rst = 1'b1;
        tick(2);

        // T1: CWF=0 linear fill of block 0x1230
        clear_logs();
        fill(2'b01, 16'h1234, 16'h0000);
        e = '{'h1230, 'h1232, 'h1234, 'h1236, 'h1238, 'h123A, 'h123C, 'h123E};
        chk_q("T1 addr", addr_q0, e);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_q("T1 idx", idx_q0, e);
        e = '{0};
        chk_q("T1 tag", tag_q0, e);

        // T2: CWF=1 critical word first, source 1
        clear_logs();
        fill(2'b10, 16'h0000, 16'h1234);
        e = '{'h1234, 'h1236, 'h1238, 'h123A, 'h123C, 'h123E, 'h1230, 'h1232};
        chk_q("T2 addr", addr_q1, e);
        e = '{2, 3, 4, 5, 6, 7, 0, 1};
        chk_q("T2 idx", idx_q1, e);
        e = '{1};
        chk_q("T2 tag", tag_q1, e);

        // T3: simultaneous misses, higher index first
        clear_logs();
        fill(2'b11, 16'h0040, 16'h0080);
        e = '{'h80, 'h82, 'h84, 'h86, 'h88, 'h8A, 'h8C, 'h8E,
              'h40, 'h42, 'h44, 'h46, 'h48, 'h4A, 'h4C, 'h4E};
        chk_q("T3 addr", addr_q0, e);
        e = '{1, 0};
        chk_q("T3 tag", tag_q0, e);
        // one dead IDLE cycle between tag write and the next grant
        chk("T3 regrant gap", gnt0_cyc - tag1_cyc, 2);

        // T4: latency 3 with stray returns while idle
        slow = 1'b1;
        clear_logs();
        stray = 1'b1; tick(1); stray = 1'b0;
        tick(2);
        fill(2'b01, 16'h2000, 16'h0000);
        stray = 1'b1; tick(1); stray = 1'b0;
        tick(4);
        slow = 1'b0;
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_q("T4 idx", idx_q0, e);
        e = '{0};
        chk_q("T4 tag", tag_q0, e);

        // T5: reset after 4 returns aborts without a tag write
        clear_logs();
        miss_addr = {16'h0000, 16'h0100};
        miss_req  = 2'b01;
        tick(5);
        rst = 1'b0;
        #1;
        chk("T5 busy",  int'(busy_w[0]), 0);
        chk("T5 grant", int'(gnt_w[0]), 0);
        chk("T5 rd_en", int'(rd_w[0]), 0);
        chk("T5 wen",   int'(wen_w[0]), 0);
        chk("T5 returns before reset", idx_q0.size(), 4);
        miss_req = 2'b00;
        tick(2);
        rst = 1'b1;
        tick(2);
        chk("T5 no tag", tag_q0.size(), 0);
        clear_logs();
        fill(2'b01, 16'h0300, 16'h0000);
        e = '{'h300, 'h302, 'h304, 'h306, 'h308, 'h30A, 'h30C, 'h30E};
        chk_q("T5 refill addr", addr_q0, e);
        e = '{0, 1, 2, 3, 4, 5, 6, 7};
        chk_q("T5 refill idx", idx_q0, e);
        e = '{0};
        chk_q("T5 refill tag", tag_q0, e);

        // T6: critical word is the last word of the block
        clear_logs();
        fill(2'b10, 16'h0000, 16'h00FE);
        e = '{'hFE, 'hF0, 'hF2, 'hF4, 'hF6, 'hF8, 'hFA, 'hFC};
        chk_q("T6 addr", addr_q1, e);
        e = '{7, 0, 1, 2, 3, 4, 5, 6};
        chk_q("T6 idx", idx_q1, e);
        e = '{'hF0, 'hF2, 'hF4, 'hF6, 'hF8, 'hFA, 'hFC, 'hFE};
        chk_q("T6 linear addr", addr_q0, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
